multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
// - Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences fetch/decode/execute/memory/writeback.
// - Sits between the instruction register opcode field and the shared-memory multicycle datapath.
// - Stalls on a memory ready handshake and traps on illegal opcodes and memory timeouts.
// - Drives every control output to a defined 0 in states that do not use it; no X outputs.
// PARAMETERS
// - MEM_TIMEOUT  16  max cycles waiting on mem_ready in one memory state before trapping; 0 disables timeout
// - EN_ITYPE     1   1: opcode 7'b0010011 executes; 0: it traps as illegal
// PORTS
// - clk        in   1  rising-edge clock
// - rst_n      in   1  asynchronous, active-low reset
// - opcode     in   7  instr[6:0] from instruction register (valid from DECODE onward)
// - zero       in   1  ALU zero flag (used in BRANCH)
// - mem_ready  in   1  memory completes current read/write this cycle
// - IorD       out  1  0: mem addr = PC; 1: mem addr = ALUOut
// - IRWrite    out  1  load instruction register
// - PCWrite    out  1  load PC
// - PCSource   out  1  0: PC <= ALU result; 1: PC <= ALUOut (branch target)
// - Branch     out  1  branch evaluation active
// - MemRead    out  1  memory read request
// - MemWrite   out  1  memory write request
// - MemtoReg   out  1  1: writeback data from MDR; 0: from ALUOut
// - ALUOp      out  2  00 ADD, 01 SUB, 10 R-type funct decode, 11 I-type funct decode
// - ALUSrcA    out  1  0: PC; 1: rs1
// - ALUSrcB    out  2  00 rs2, 01 const 4, 10 immediate
// - RegWrite   out  1  write register file
// - retire     out  1  one-cycle pulse in the final state of each completed instruction
// - trap       out  1  sticky; high in TRAP
// - trap_cause out  2  00 none, 01 illegal opcode, 10 memory timeout; held until reset
// BEHAVIOUR
// - Async reset: state <= FETCH, timeout counter <= 0, trap_cause <= 00. All outputs then decode from FETCH as listed below.
// - Outputs are combinational from state; IRWrite/PCWrite in FETCH and advance out of memory states are also gated by mem_ready.
// - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
//   - If mem_ready: IRWrite=1, PCWrite=1, PCSource=0, go to DECODE. Otherwise stay.
// - DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; ALUOut captures the branch target. Dispatch on opcode:
//   - 0000011 or 0100011 -> MEMADR
//   - 0110011 -> EXEC_R
//   - 0010011 -> EXEC_I if EN_ITYPE, else TRAP with cause 01
//   - 1100011 -> BRANCH
//   - any other opcode -> TRAP with cause 01
// - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if opcode==0000011, else MEMWR.
// - MEMRD: IorD=1, MemRead=1. On mem_ready go to MEMWB; otherwise stay.
// - MEMWB: RegWrite=1, MemtoReg=1, retire=1; go to FETCH.
// - MEMWR: IorD=1, MemWrite=1. On mem_ready: retire=1, go to FETCH.
// - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB.
// - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11; go to ALUWB.
// - ALUWB: RegWrite=1, MemtoReg=0, retire=1; go to FETCH.
// - BRANCH: Branch=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero, retire=1; go to FETCH.
// - TRAP: all control outputs 0, trap=1. Absorbing state; only rst_n exits.
// - Latency with mem_ready=1 every cycle (cycles per instruction):
//   - R/I-type 4, load 5, store 4, branch 3.
// - Timeout counter:
//   - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
//   - Clears on every state change.
//   - If MEM_TIMEOUT>0 and the counter == MEM_TIMEOUT-1 while mem_ready=0, next state is TRAP with cause 10.
//   - mem_ready=1 in that same cycle wins: the state advances normally and no trap is taken.
// - Counter width: $clog2(MEM_TIMEOUT+1), minimum 1 bit.
// - Reset asserted mid-instruction aborts immediately; no retire pulse is issued.
// - opcode is sampled only in DECODE and MEMADR; changes in any other state are ignored.
// TESTING
// - Reset, opcode=0110011, mem_ready=1 -> states FETCH,DECODE,EXEC_R,ALUWB; RegWrite=1 only in cycle 4; retire pulse in cycle 4.
// - Load 0000011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB with MemtoReg=1; total 8 cycles.
// - Branch 1100011 with zero=1 -> PCWrite=1, PCSource=1 in BRANCH; repeat with zero=0 -> PCWrite=0.
// - opcode=7'b1111111 -> TRAP after DECODE, trap=1, trap_cause=01, outputs 0 for 20 cycles; rst_n low -> FETCH.
// - MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered on cycle 5, trap_cause=10; mem_ready=1 on 4th wait cycle -> no trap.
// - EN_ITYPE=0, opcode=0010011 -> TRAP with cause 01; rst_n pulsed low during MEMWR -> FETCH next edge, no retire.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the shared-memory datapath.
// Latency: none; this is a plain bundle of wires.
// Backpressure: mem_ready from the memory side stalls the control unit.
// Ports:
//   opcode, zero, mem_ready -> inputs to the control unit (datapath / memory side)
//   IorD .. RegWrite        -> datapath control strobes from the control unit
//   retire, trap, trap_cause-> status from the control unit
// Modports: master = control unit, slave = datapath.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSource;
  logic       Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, zero, mem_ready,
    output IorD, IRWrite, PCWrite, PCSource, Branch, MemRead, MemWrite,
           MemtoReg, ALUOp, ALUSrcA, ALUSrcB, RegWrite, retire, trap, trap_cause
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IorD, IRWrite, PCWrite, PCSource, Branch, MemRead, MemWrite,
           MemtoReg, ALUOp, ALUSrcA, ALUSrcB, RegWrite, retire, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for a shared-memory multicycle datapath.
// Latency: R/I-type 4, store 4, load 5, branch 3 cycles per instruction with memory always ready.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; a wait of MEM_TIMEOUT cycles traps.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, returns to FETCH and clears trap_cause
//   bus   - control interface (master side): opcode/zero/mem_ready in, control strobes and status out
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_ITYPE    = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  localparam int CW_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  // Last count value before the wait is declared dead; meaningless when MEM_TIMEOUT is 0.
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   tcnt;
  logic [1:0]      cause_q;
  logic            waiting;
  logic            timed_out;

  // States that block on the memory handshake.
  assign waiting   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // mem_ready in the final allowed cycle still wins, hence the !mem_ready term.
  assign timed_out = (MEM_TIMEOUT > 0) && waiting && !bus.mem_ready && (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tcnt    <= '0;
      cause_q <= 2'b00;
    end else begin
      unique case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXEC_R;
            OP_ITYPE: begin
              if (EN_ITYPE) begin
                state <= S_EXEC_I;
              end else begin
                state   <= S_TRAP;
                cause_q <= 2'b01;
              end
            end
            OP_BRANCH:         state <= S_BRANCH;
            default: begin
              state   <= S_TRAP;
              cause_q <= 2'b01;
            end
          endcase
        end
        // Opcode is re-sampled here to pick the read or write leg.
        S_MEMADR: state <= (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXEC_R: state <= S_ALUWB;
        S_EXEC_I: state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase

      if (timed_out) begin
        state   <= S_TRAP;
        cause_q <= 2'b10;
      end

      // Counts only stalled cycles; any advance (or leaving a wait state) restarts it.
      if (waiting && !bus.mem_ready && !timed_out) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  always_comb begin
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSource = 1'b0;
    bus.Branch   = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.RegWrite = 1'b0;
    bus.retire   = 1'b0;
    bus.trap     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        // PC+4 and the IR load only commit when the fetch completes.
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
        end
      end
      S_DECODE: bus.ALUSrcB = 2'b10;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.retire   = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        bus.retire   = bus.mem_ready;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 2'b11;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_BRANCH: begin
        bus.Branch   = 1'b1;
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 2'b01;
        bus.PCSource = 1'b1;
        bus.PCWrite  = bus.zero;
        bus.retire   = 1'b1;
      end
      S_TRAP:  bus.trap = 1'b1;
      default: ;
    endcase
  end

  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (timeout 4 with I-type, timeout off without I-type)
// share one stimulus stream; every cycle both are compared to an instruction-step reference model.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcsource;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       retire;
    logic       trap;
    logic [1:0] cause;
  } ctl_t;

  localparam int K_NONE = 0, K_ALU_R = 1, K_ALU_I = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multicycle_control_unit_if bus_a ();
  multicycle_control_unit_if bus_b ();

  multicycle_control_unit #(.MEM_TIMEOUT(4), .EN_ITYPE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  multicycle_control_unit #(.MEM_TIMEOUT(0), .EN_ITYPE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  ctl_t vec_a, vec_b, obs_a, obs_b;
  assign vec_a = {bus_a.IorD, bus_a.IRWrite, bus_a.PCWrite, bus_a.PCSource, bus_a.Branch,
                  bus_a.MemRead, bus_a.MemWrite, bus_a.MemtoReg, bus_a.ALUOp, bus_a.ALUSrcA,
                  bus_a.ALUSrcB, bus_a.RegWrite, bus_a.retire, bus_a.trap, bus_a.trap_cause};
  assign vec_b = {bus_b.IorD, bus_b.IRWrite, bus_b.PCWrite, bus_b.PCSource, bus_b.Branch,
                  bus_b.MemRead, bus_b.MemWrite, bus_b.MemtoReg, bus_b.ALUOp, bus_b.ALUSrcA,
                  bus_b.ALUSrcB, bus_b.RegWrite, bus_b.retire, bus_b.trap, bus_b.trap_cause};

  // Reference model: instruction kind plus cycle index within the instruction.
  int       step_m [2];
  int       cls_m  [2];
  int       wcnt_m [2];
  bit       trp_m  [2];
  logic [1:0] cause_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input int d);
    step_m[d]  = 0;
    cls_m[d]   = K_NONE;
    wcnt_m[d]  = 0;
    trp_m[d]   = 1'b0;
    cause_m[d] = 2'b00;
  endfunction

  function automatic ctl_t model_out(input int d, input logic z, input logic mr);
    ctl_t c;
    c = '0;
    if (trp_m[d]) begin
      c.trap  = 1'b1;
      c.cause = cause_m[d];
      return c;
    end
    case (step_m[d])
      0: begin
        c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr;
      end
      1: c.alusrcb = 2'b10;
      2: begin
        case (cls_m[d])
          K_LOAD, K_STORE: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          K_ALU_R: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
          K_ALU_I: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; end
          K_BR: begin
            c.branch = 1'b1; c.alusrca = 1'b1; c.aluop = 2'b01;
            c.pcsource = 1'b1; c.pcwrite = z; c.retire = 1'b1;
          end
          default: ;
        endcase
      end
      3: begin
        case (cls_m[d])
          K_LOAD:  begin c.iord = 1'b1; c.memread = 1'b1; end
          K_STORE: begin c.iord = 1'b1; c.memwrite = 1'b1; c.retire = mr; end
          default: begin c.regwrite = 1'b1; c.retire = 1'b1; end
        endcase
      end
      4: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.retire = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic void model_adv(input int d, input logic [6:0] opc, input logic mr);
    int to;
    bit ity;
    bit waiting;
    to  = (d == 0) ? 4 : 0;
    ity = (d == 0);
    if (trp_m[d]) return;
    waiting = (step_m[d] == 0) || (step_m[d] == 3 && (cls_m[d] == K_LOAD || cls_m[d] == K_STORE));
    if (waiting && !mr) begin
      if (to > 0 && wcnt_m[d] == to - 1) begin
        trp_m[d] = 1'b1; cause_m[d] = 2'b10;
      end else begin
        wcnt_m[d]++;
      end
      return;
    end
    wcnt_m[d] = 0;
    case (step_m[d])
      0: step_m[d] = 1;
      1: begin
        step_m[d] = 2;
        if (opc == 7'b0000011)                cls_m[d] = K_LOAD;
        else if (opc == 7'b0100011)           cls_m[d] = K_STORE;
        else if (opc == 7'b0110011)           cls_m[d] = K_ALU_R;
        else if (opc == 7'b0010011 && ity)    cls_m[d] = K_ALU_I;
        else if (opc == 7'b1100011)           cls_m[d] = K_BR;
        else begin trp_m[d] = 1'b1; cause_m[d] = 2'b01; end
      end
      2: begin
        if (cls_m[d] == K_BR) step_m[d] = 0;
        else begin
          if (cls_m[d] == K_LOAD || cls_m[d] == K_STORE)
            cls_m[d] = (opc == 7'b0000011) ? K_LOAD : K_STORE;
          step_m[d] = 3;
        end
      end
      3: step_m[d] = (cls_m[d] == K_LOAD) ? 4 : 0;
      default: step_m[d] = 0;
    endcase
  endfunction

  // One clock: drive at negedge, compare both instances shortly after, advance the model at posedge.
  task automatic step(input logic [6:0] opc, input logic z, input logic mr, input logic rn);
    @(negedge clk);
    bus_a.opcode = opc; bus_a.zero = z; bus_a.mem_ready = mr;
    bus_b.opcode = opc; bus_b.zero = z; bus_b.mem_ready = mr;
    rst_n = rn;
    if (!rn) begin
      model_reset(0);
      model_reset(1);
    end
    #1;
    obs_a = vec_a;
    obs_b = vec_b;
    chk("ctl_a", 32'(obs_a), 32'(model_out(0, z, mr)));
    chk("ctl_b", 32'(obs_b), 32'(model_out(1, z, mr)));
    @(posedge clk);
    if (rn) begin
      model_adv(0, opc, mr);
      model_adv(1, opc, mr);
    end
  endtask

  initial begin
    int rc;
    int wc;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_a.opcode = '0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b0;
    bus_b.opcode = '0; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;
    model_reset(0);
    model_reset(1);

    // Reset state
    step(7'h33, 1'b0, 1'b0, 1'b0);
    chk("rst_memread", 32'(obs_a.memread), 32'd1);
    chk("rst_srcb", 32'(obs_a.alusrcb), 32'd1);
    chk("rst_cause", 32'(obs_a.cause), 32'd0);

    // R-type, memory always ready: 4 cycles, single writeback/retire in cycle 4
    rc = 0; wc = 0;
    for (int i = 1; i <= 4; i++) begin
      step(7'b0110011, 1'b0, 1'b1, 1'b1);
      rc += int'(obs_a.retire);
      wc += int'(obs_a.regwrite);
    end
    chk("r_retire_c4", 32'(obs_a.retire), 32'd1);
    chk("r_regwrite_cnt", 32'(wc), 32'd1);
    chk("r_retire_cnt", 32'(rc), 32'd1);

    // Load with three stalled read cycles: 8 cycles, writeback from MDR
    step(7'h00, 1'b0, 1'b1, 1'b0);
    rc = 0;
    step(7'b0000011, 1'b0, 1'b1, 1'b1);
    step(7'b0000011, 1'b0, 1'b1, 1'b1);
    step(7'b0000011, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(7'b0000011, 1'b0, 1'b0, 1'b1);
      rc += int'(obs_a.retire);
    end
    step(7'b0000011, 1'b0, 1'b1, 1'b1);
    chk("ld_rd_iord", 32'(obs_a.iord), 32'd1);
    step(7'b0000011, 1'b0, 1'b1, 1'b1);
    chk("ld_memtoreg", 32'(obs_a.memtoreg), 32'd1);
    chk("ld_retire_c8", 32'(obs_a.retire), 32'd1);
    chk("ld_no_early_retire", 32'(rc), 32'd0);

    // Branch taken / not taken
    step(7'h00, 1'b0, 1'b1, 1'b0);
    step(7'b1100011, 1'b1, 1'b1, 1'b1);
    step(7'b1100011, 1'b1, 1'b1, 1'b1);
    step(7'b1100011, 1'b1, 1'b1, 1'b1);
    chk("br_taken_pcwrite", 32'(obs_a.pcwrite), 32'd1);
    chk("br_pcsource", 32'(obs_a.pcsource), 32'd1);
    step(7'b1100011, 1'b0, 1'b1, 1'b1);
    step(7'b1100011, 1'b0, 1'b1, 1'b1);
    step(7'b1100011, 1'b0, 1'b1, 1'b1);
    chk("br_nt_pcwrite", 32'(obs_a.pcwrite), 32'd0);
    chk("br_nt_branch", 32'(obs_a.branch), 32'd1);

    // Illegal opcode: absorbing trap with cause 01 and all controls low
    step(7'h00, 1'b0, 1'b1, 1'b0);
    step(7'b1111111, 1'b0, 1'b1, 1'b1);
    step(7'b1111111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      chk("ill_trap_vec", 32'(obs_a), 32'h5);
    end
    step(7'b1111111, 1'b0, 1'b1, 1'b0);
    chk("ill_rst_trap", 32'(obs_a.trap), 32'd0);
    chk("ill_rst_memread", 32'(obs_a.memread), 32'd1);

    // Timeout: four stalled fetch cycles trap on cycle 5 (instance b has the timeout off)
    for (int i = 0; i < 4; i++) step(7'b0110011, 1'b0, 1'b0, 1'b1);
    step(7'b0110011, 1'b0, 1'b0, 1'b1);
    chk("to_trap", 32'(obs_a.trap), 32'd1);
    chk("to_cause", 32'(obs_a.cause), 32'd2);
    chk("to_off_notrap", 32'(obs_b.trap), 32'd0);
    // Ready arriving in the last allowed cycle wins
    step(7'b0110011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(7'b0110011, 1'b0, 1'b0, 1'b1);
    step(7'b0110011, 1'b0, 1'b1, 1'b1);
    chk("to_edge_irwrite", 32'(obs_a.irwrite), 32'd1);
    step(7'b0110011, 1'b0, 1'b1, 1'b1);
    chk("to_edge_notrap", 32'(obs_a.trap), 32'd0);
    chk("to_edge_decode", 32'(obs_a.alusrcb), 32'd2);

    // I-type: executes in instance a, illegal in instance b
    step(7'h00, 1'b0, 1'b1, 1'b0);
    step(7'b0010011, 1'b0, 1'b1, 1'b1);
    step(7'b0010011, 1'b0, 1'b1, 1'b1);
    step(7'b0010011, 1'b0, 1'b1, 1'b1);
    chk("ity_a_aluop", 32'(obs_a.aluop), 32'd3);
    chk("ity_b_trap", 32'(obs_b.trap), 32'd1);
    chk("ity_b_cause", 32'(obs_b.cause), 32'd1);

    // Reset during a stalled store write: no retire, back in FETCH
    step(7'h00, 1'b0, 1'b1, 1'b0);
    step(7'b0100011, 1'b0, 1'b1, 1'b1);
    step(7'b0100011, 1'b0, 1'b1, 1'b1);
    step(7'b0100011, 1'b0, 1'b1, 1'b1);
    step(7'b0100011, 1'b0, 1'b0, 1'b1);
    chk("st_memwrite", 32'(obs_a.memwrite), 32'd1);
    step(7'b0100011, 1'b0, 1'b1, 1'b0);
    chk("st_rst_retire", 32'(obs_a.retire), 32'd0);
    chk("st_rst_memwrite", 32'(obs_a.memwrite), 32'd0);
    chk("st_rst_memread", 32'(obs_a.memread), 32'd1);
    step(7'b0100011, 1'b0, 1'b1, 1'b1);
    chk("st_rst_fetch", 32'(obs_a.irwrite), 32'd1);

    // Random traffic against the model, opcode changing every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] opc;
      logic       mr;
      logic       rn;
      int         sel;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: opc = 7'b0000011;
        1: opc = 7'b0100011;
        2: opc = 7'b0110011;
        3: opc = 7'b0010011;
        4: opc = 7'b1100011;
        5: opc = 7'b1111111;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      mr = ($urandom_range(0, 99) < 70);
      if (trp_m[0] && trp_m[1]) rn = ($urandom_range(0, 3) != 0);
      else if (trp_m[0] || trp_m[1]) rn = ($urandom_range(0, 19) != 0);
      else rn = ($urandom_range(0, 299) != 0);
      step(opc, 1'($urandom_range(0, 1)), mr, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
